// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display: FSM states,
// 7-segment patterns and the double-dabble nibble adjust.
package score_disp_pkg;

    localparam int SCORE_W = 7;
    localparam int DIGITS  = 3;
    localparam int BCD_W   = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV_CURR,
        CONV_HIGH,
        UPDATE
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Double-dabble pre-shift step: every BCD nibble >= 5 gets +3
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to a 7-segment pattern, with a forced-blank input
// used for leading-zero suppression.
module seg7_decode
    import score_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Pure decode; out-of-range nibbles show nothing
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Score display: one serial double-dabble converter shared between the
// current and high scores, digit registers, 7-segment decode, and a
// latched game-over flag that blinks the current-score digits.
module score_display
    import score_disp_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES  = 25_000_000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] currScore,
    input  logic [SCORE_W-1:0] highScore,
    input  logic               isGameComplete,
    output logic [6:0]         curr_ss2,
    output logic [6:0]         curr_ss1,
    output logic [6:0]         curr_ss0,
    output logic [6:0]         high_ss2,
    output logic [6:0]         high_ss1,
    output logic [6:0]         high_ss0,
    output logic               busy,
    output logic               done,
    output logic               game_over
);

    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    state_t               state_reg;
    logic [SCORE_W-1:0]   snap_curr_reg, snap_high_reg;
    logic [SCORE_W-1:0]   bin_reg;
    logic [BCD_W-1:0]     bcd_reg, hold_reg;
    logic [2:0]           cnt_reg;
    logic [BCD_W-1:0]     curr_dig_reg, high_dig_reg;
    logic                 done_reg;
    logic                 game_over_reg, game_over_next;
    logic [BLINK_W-1:0]   blink_cnt_reg;
    logic                 phase_on_reg;

    logic                       inputs_changed;
    logic [BCD_W+SCORE_W-1:0]   dd_shift;
    logic [DIGITS-1:0]          curr_blank, high_blank;
    logic [6:0]                 curr_seg [DIGITS];
    logic [6:0]                 high_seg [DIGITS];

    assign inputs_changed = {currScore, highScore} != {snap_curr_reg, snap_high_reg};
    // One double-dabble step: adjust nibbles, then shift {bcd,bin} left
    assign dd_shift = {dd_adjust(bcd_reg), bin_reg} << 1;

    // Conversion FSM: snapshot, 7 shifts current, 7 shifts high, publish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            snap_curr_reg <= '0;
            snap_high_reg <= '0;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            hold_reg      <= '0;
            cnt_reg       <= '0;
            curr_dig_reg  <= '0;
            high_dig_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (inputs_changed) begin
                        snap_curr_reg <= currScore;
                        snap_high_reg <= highScore;
                        bin_reg       <= currScore;
                        bcd_reg       <= '0;
                        cnt_reg       <= '0;
                        state_reg     <= CONV_CURR;
                    end
                end
                CONV_CURR: begin
                    if (cnt_reg == 3'd6) begin
                        hold_reg  <= dd_shift[BCD_W+SCORE_W-1:SCORE_W];
                        bin_reg   <= snap_high_reg;
                        bcd_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= CONV_HIGH;
                    end else begin
                        bcd_reg <= dd_shift[BCD_W+SCORE_W-1:SCORE_W];
                        bin_reg <= dd_shift[SCORE_W-1:0];
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                CONV_HIGH: begin
                    bcd_reg <= dd_shift[BCD_W+SCORE_W-1:SCORE_W];
                    bin_reg <= dd_shift[SCORE_W-1:0];
                    if (cnt_reg == 3'd6) begin
                        cnt_reg   <= '0;
                        state_reg <= UPDATE;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                UPDATE: begin
                    curr_dig_reg <= hold_reg;
                    high_dig_reg <= bcd_reg;
                    done_reg     <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Game over is set by the tracker and cleared once a nonzero score is taken
    always_comb begin
        game_over_next = game_over_reg;
        if (state_reg == IDLE && inputs_changed && currScore != '0)
            game_over_next = 1'b0;
        if (isGameComplete)
            game_over_next = 1'b1;
    end

    // Game-over flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            game_over_reg <= 1'b0;
        else
            game_over_reg <= game_over_next;
    end

    // Blink timer: restarts in the on phase whenever game over begins or ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
        end else if (!game_over_reg || !game_over_next) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= 1'b1;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_on_reg  <= ~phase_on_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Leading-zero suppression: hundreds if zero, tens if both upper digits zero
    always_comb begin
        curr_blank    = '0;
        high_blank    = '0;
        curr_blank[2] = BLANK_LEADING && (curr_dig_reg[11:8] == 4'd0);
        curr_blank[1] = curr_blank[2] && (curr_dig_reg[7:4] == 4'd0);
        high_blank[2] = BLANK_LEADING && (high_dig_reg[11:8] == 4'd0);
        high_blank[1] = high_blank[2] && (high_dig_reg[7:4] == 4'd0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            seg7_decode u_curr (
                .bcd   (curr_dig_reg[4*gi +: 4]),
                .blank (curr_blank[gi]),
                .seg   (curr_seg[gi])
            );
            seg7_decode u_high (
                .bcd   (high_dig_reg[4*gi +: 4]),
                .blank (high_blank[gi]),
                .seg   (high_seg[gi])
            );
        end
    endgenerate

    assign curr_ss2  = phase_on_reg ? curr_seg[2] : SEG_BLANK;
    assign curr_ss1  = phase_on_reg ? curr_seg[1] : SEG_BLANK;
    assign curr_ss0  = phase_on_reg ? curr_seg[0] : SEG_BLANK;
    assign high_ss2  = high_seg[2];
    assign high_ss1  = high_seg[1];
    assign high_ss0  = high_seg[0];
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign game_over = game_over_reg;

endmodule
